// File: rtl/secded_inv_22_16_pkg.sv
// secded_inv_22_16_pkg
// Shared constants for the inverted Hamming (22,16) SECDED encoder stage:
// data/code widths, the five Hamming check masks, the codeword inversion
// constant and the skid-buffer occupancy encoding.
package secded_inv_22_16_pkg;

    localparam int DATA_W = 16;
    localparam int CODE_W = 22;
    localparam int CHK_W  = 6;

    localparam logic [DATA_W-1:0] ENC_M0 = 16'had5b;
    localparam logic [DATA_W-1:0] ENC_M1 = 16'h366d;
    localparam logic [DATA_W-1:0] ENC_M2 = 16'hc78e;
    localparam logic [DATA_W-1:0] ENC_M3 = 16'h07f0;
    localparam logic [DATA_W-1:0] ENC_M4 = 16'hf800;

    // Inverts check bits 17, 19 and 21 so an all-zero word never stores as all-zero.
    localparam logic [CODE_W-1:0] INV_MASK = 22'h2a0000;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

endpackage

// File: rtl/prim_secded_inv_hamming_22_16_enc.sv
// prim_secded_inv_hamming_22_16_enc
// Purely combinational inverted Hamming (22,16) SECDED encoder.
// Ports:
//   data_i  [15:0]  data word
//   code_o  [21:0]  codeword {check[5:0], data[15:0]}, inversion applied
module prim_secded_inv_hamming_22_16_enc
    import secded_inv_22_16_pkg::*;
(
    input  logic [DATA_W-1:0] data_i,
    output logic [CODE_W-1:0] code_o
);

    logic [CODE_W-2:0] raw_lo;

    assign raw_lo = {^(data_i & ENC_M4),
                     ^(data_i & ENC_M3),
                     ^(data_i & ENC_M2),
                     ^(data_i & ENC_M1),
                     ^(data_i & ENC_M0),
                     data_i};

    // Overall parity covers data and the five Hamming checks (pre-inversion).
    assign code_o = {^raw_lo, raw_lo} ^ INV_MASK;

endmodule

// File: rtl/secded_inv_hamming_22_16_enc_stage.sv
// secded_inv_hamming_22_16_enc_stage
// Registered valid/ready write-path stage producing inverted Hamming (22,16)
// SECDED codewords. An output register plus a one-entry skid register give
// full throughput with a registered in_ready_o.
// Optional error injection is compiled in with macro SECDED_ENC_ERR_INJ_EN;
// without it the injection inputs are ignored and inj_pending_o is 0.
// Ports:
//   clk_i, rst_i (async, active-high)
//   in_valid_i / in_ready_o / in_data_i[15:0]     input word handshake
//   out_valid_o / out_ready_i / out_data_o[21:0]  codeword handshake
//   inj_arm_i / inj_mask_i[21:0] / inj_pending_o  one-shot error injection
//
// state     | meaning
// ----------+-------------------------------------------
// OCC_EMPTY | no codeword held, out_valid_o low
// OCC_ONE   | OUT holds a codeword, SKID empty
// OCC_FULL  | OUT and SKID both hold codewords, in_ready_o low
module secded_inv_hamming_22_16_enc_stage
    import secded_inv_22_16_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CODE_W-1:0] out_data_o,
    input  logic              inj_arm_i,
    input  logic [CODE_W-1:0] inj_mask_i,
    output logic              inj_pending_o
);

    occ_e              state_q, state_d;
    logic [CODE_W-1:0] out_data_q, out_data_d;
    logic [CODE_W-1:0] skid_data_q, skid_data_d;
    logic              in_ready_q;
    logic [CODE_W-1:0] enc_code;
    logic [CODE_W-1:0] inj_xor;
    logic [CODE_W-1:0] store_code;
    logic              in_fire;
    logic              out_fire;

    assign in_fire  = in_valid_i & in_ready_q;
    assign out_fire = (state_q != OCC_EMPTY) & out_ready_i;

    prim_secded_inv_hamming_22_16_enc u_enc (
        .data_i (in_data_i),
        .code_o (enc_code)
    );

`ifdef SECDED_ENC_ERR_INJ_EN
    logic              inj_pending_q, inj_pending_d;
    logic [CODE_W-1:0] inj_mask_q, inj_mask_d;
    logic              inj_apply;

    // A word accepted in the arming cycle stays clean; the new mask waits for the next word.
    assign inj_apply = inj_pending_q & in_fire & ~inj_arm_i;

    always_comb begin
        inj_pending_d = inj_pending_q;
        inj_mask_d    = inj_mask_q;
        if (inj_arm_i) begin
            inj_pending_d = 1'b1;
            inj_mask_d    = inj_mask_i;
        end else if (inj_apply) begin
            inj_pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            inj_pending_q <= 1'b0;
            inj_mask_q    <= '0;
        end else begin
            inj_pending_q <= inj_pending_d;
            inj_mask_q    <= inj_mask_d;
        end
    end

    assign inj_xor       = inj_apply ? inj_mask_q : '0;
    assign inj_pending_o = inj_pending_q;
`else
    logic unused_inj;

    assign unused_inj    = ^{inj_arm_i, inj_mask_i};
    assign inj_xor       = '0;
    assign inj_pending_o = 1'b0;
`endif

    assign store_code = enc_code ^ inj_xor;

    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        skid_data_d = skid_data_q;
        unique case (state_q)
            OCC_EMPTY: begin
                if (in_fire) begin
                    out_data_d = store_code;
                    state_d    = OCC_ONE;
                end
            end
            OCC_ONE: begin
                case ({in_fire, out_fire})
                    2'b11: out_data_d = store_code;
                    2'b10: begin
                        skid_data_d = store_code;
                        state_d     = OCC_FULL;
                    end
                    2'b01: state_d = OCC_EMPTY;
                    default: ;
                endcase
            end
            OCC_FULL: begin
                // in_ready_o is low here, so in_fire is normally 0; kept general.
                if (out_fire) begin
                    out_data_d = skid_data_q;
                    if (in_fire) begin
                        skid_data_d = store_code;
                    end else begin
                        state_d = OCC_ONE;
                    end
                end
            end
            default: state_d = OCC_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= OCC_EMPTY;
            out_data_q  <= '0;
            skid_data_q <= '0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            skid_data_q <= skid_data_d;
            in_ready_q  <= (state_d != OCC_FULL);
        end
    end

    assign out_valid_o = (state_q != OCC_EMPTY);
    assign out_data_o  = out_data_q;
    assign in_ready_o  = in_ready_q;

endmodule

// File: tb/tb_secded_inv_hamming_22_16_enc_stage.sv
// tb_secded_inv_hamming_22_16_enc_stage
// Self-checking bench: queue scoreboard fed by an arithmetic reference encoder,
// plus a reference decoder that classifies codewords by syndrome.
module tb_secded_inv_hamming_22_16_enc_stage;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [15:0] in_data_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [21:0] out_data_o;
    logic        inj_arm_i = 1'b0;
    logic [21:0] inj_mask_i = '0;
    logic        inj_pending_o;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [15:0] HM [5] = '{16'had5b, 16'h366d, 16'hc78e, 16'h07f0, 16'hf800};

    logic [21:0] exp_q[$];
    logic        pend_m = 1'b0;
    logic [21:0] mask_m = '0;

    secded_inv_hamming_22_16_enc_stage dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .in_data_i     (in_data_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_data_o    (out_data_o),
        .inj_arm_i     (inj_arm_i),
        .inj_mask_i    (inj_mask_i),
        .inj_pending_o (inj_pending_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [21:0] ref_enc(input logic [15:0] d);
        logic [21:0] raw;
        raw = {6'b0, d};
        for (int k = 0; k < 5; k++) begin
            raw[16+k] = 1'($countones(d & HM[k]) % 2);
        end
        raw[21] = 1'($countones(raw[20:0]) % 2);
        return raw ^ 22'h2a0000;
    endfunction

    // 00 clean, 01 single (odd overall parity), 10 double (even parity, nonzero syndrome)
    function automatic logic [1:0] ref_dec_err(input logic [21:0] cw);
        logic [21:0] raw;
        logic [4:0]  syn;
        logic        par;
        raw = cw ^ 22'h2a0000;
        for (int k = 0; k < 5; k++) begin
            syn[k] = raw[16+k] ^ 1'($countones(raw[15:0] & HM[k]) % 2);
        end
        par = 1'($countones(raw) % 2);
        if (par) return 2'b01;
        if (syn != 5'd0) return 2'b10;
        return 2'b00;
    endfunction

    // Drives one cycle from a negedge to the next negedge and updates the model.
    task automatic drive_cycle(input logic vld, input logic [15:0] d, input logic ordy,
                               input logic arm, input logic [21:0] mask,
                               output logic ifire, output logic ofire, output logic [21:0] odata);
        logic [21:0] cw;
        in_valid_i  = vld;
        in_data_i   = d;
        out_ready_i = ordy;
        inj_arm_i   = arm;
        inj_mask_i  = mask;
        #1;
        ifire = vld & in_ready_o;
        ofire = out_valid_o & ordy;
        odata = out_data_o;
        if (ofire && exp_q.size() > 0) void'(exp_q.pop_front());
        if (ifire) begin
            cw = ref_enc(d);
`ifdef SECDED_ENC_ERR_INJ_EN
            if (pend_m && !arm) begin
                cw     = cw ^ mask_m;
                pend_m = 1'b0;
            end
`endif
            exp_q.push_back(cw);
        end
`ifdef SECDED_ENC_ERR_INJ_EN
        if (arm) begin
            pend_m = 1'b1;
            mask_m = mask;
        end
`endif
        @(posedge clk_i);
        @(negedge clk_i);
        inj_arm_i = 1'b0;
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        vectors++;
        if (out_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid_o); end
        vectors++;
        if (out_data_o !== 22'h0) begin miscompares++; $display("FAIL reset_out_data: got %h expected 000000", out_data_o); end
        vectors++;
        if (in_ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 1", in_ready_o); end
        vectors++;
        if (inj_pending_o !== 1'b0) begin miscompares++; $display("FAIL reset_inj_pending: got %b expected 0", inj_pending_o); end
        @(negedge clk_i);
    endtask

    task automatic test_directed;
        logic fi, fo;
        logic [21:0] od;
        drive_cycle(1'b1, 16'h0000, 1'b1, 1'b0, 22'h0, fi, fo, od);
        vectors++;
        if (out_valid_o !== 1'b1) begin miscompares++; $display("FAIL dir_latency_valid: got %b expected 1", out_valid_o); end
        vectors++;
        if (out_data_o !== 22'h2a0000) begin miscompares++; $display("FAIL dir_zero_word: got %h expected 2a0000", out_data_o); end
        drive_cycle(1'b1, 16'hffff, 1'b1, 1'b0, 22'h0, fi, fo, od);
        vectors++;
        if (out_data_o !== 22'h34ffff) begin miscompares++; $display("FAIL dir_ones_word: got %h expected 34ffff", out_data_o); end
        drive_cycle(1'b0, 16'h0, 1'b1, 1'b0, 22'h0, fi, fo, od);
        vectors++;
        if (out_valid_o !== 1'b0) begin miscompares++; $display("FAIL dir_drained: got %b expected 0", out_valid_o); end
    endtask

    task automatic test_syndrome;
        logic fi, fo;
        logic [21:0] od;
        for (int i = 0; i < 10000; i++) begin
            if (exp_q.size() > 0) begin
                vectors++;
                if (out_data_o !== exp_q[0]) begin miscompares++; $display("FAIL syn_data: got %h expected %h", out_data_o, exp_q[0]); end
                vectors++;
                if (ref_dec_err(out_data_o) !== 2'b00) begin miscompares++; $display("FAIL syn_zero: cw %h err %b expected 00", out_data_o, ref_dec_err(out_data_o)); end
            end
            drive_cycle(1'b1, 16'($urandom), 1'b1, 1'b0, 22'h0, fi, fo, od);
            vectors++;
            if (fi !== 1'b1) begin miscompares++; $display("FAIL syn_throughput: accept %b expected 1", fi); end
        end
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) drive_cycle(1'b0, 16'h0, 1'b1, 1'b0, 22'h0, fi, fo, od);
        vectors++;
        if (exp_q.size() != 0 || out_valid_o !== 1'b0) begin miscompares++; $display("FAIL syn_drain: left %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_backpressure;
        logic fi, fo;
        logic [21:0] od;
        int sent = 0;
        int recv = 0;
        for (int cyc = 0; cyc < 100 && recv < 16; cyc++) begin
            if (cyc == 2) begin
                vectors++;
                if (in_ready_o !== 1'b0 || sent != 2) begin miscompares++; $display("FAIL bp_ready_fall: in_ready %b accepts %0d expected 0 and 2", in_ready_o, sent); end
            end
            vectors++;
            if (in_ready_o !== (exp_q.size() < 2)) begin miscompares++; $display("FAIL bp_ready: got %b expected %b", in_ready_o, exp_q.size() < 2); end
            drive_cycle(sent < 16, 16'(sent), cyc >= 3, 1'b0, 22'h0, fi, fo, od);
            if (fi) sent++;
            if (fo) begin
                vectors++;
                if (od !== ref_enc(16'(recv))) begin miscompares++; $display("FAIL bp_order: got %h expected %h", od, ref_enc(16'(recv))); end
                recv++;
            end
        end
        vectors++;
        if (recv != 16 || out_valid_o !== 1'b0) begin miscompares++; $display("FAIL bp_count: got %0d expected 16", recv); end
    endtask

    task automatic test_random;
        logic fi, fo;
        logic [21:0] od;
        logic stall_prev = 1'b0;
        logic [21:0] data_prev = '0;
        for (int i = 0; i < 3000; i++) begin
            vectors++;
            if (out_valid_o !== (exp_q.size() > 0)) begin miscompares++; $display("FAIL rnd_valid: got %b expected %b", out_valid_o, exp_q.size() > 0); end
            vectors++;
            if (in_ready_o !== (exp_q.size() < 2)) begin miscompares++; $display("FAIL rnd_ready: got %b expected %b", in_ready_o, exp_q.size() < 2); end
            if (exp_q.size() > 0) begin
                vectors++;
                if (out_data_o !== exp_q[0]) begin miscompares++; $display("FAIL rnd_data: got %h expected %h", out_data_o, exp_q[0]); end
            end
            if (stall_prev) begin
                vectors++;
                if (out_data_o !== data_prev) begin miscompares++; $display("FAIL rnd_stable: got %h expected %h", out_data_o, data_prev); end
            end
            drive_cycle(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0, 22'h0, fi, fo, od);
            stall_prev = out_valid_o & ~out_ready_i & ~fo;
            stall_prev = (od === out_data_o) ? stall_prev : 1'b0;
            stall_prev = stall_prev & !fo & (exp_q.size() > 0);
            data_prev  = od;
        end
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
            vectors++;
            if (out_data_o !== exp_q[0]) begin miscompares++; $display("FAIL rnd_drain_data: got %h expected %h", out_data_o, exp_q[0]); end
            drive_cycle(1'b0, 16'h0, 1'b1, 1'b0, 22'h0, fi, fo, od);
        end
        vectors++;
        if (exp_q.size() != 0 || out_valid_o !== 1'b0) begin miscompares++; $display("FAIL rnd_drain: left %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_injection;
        logic fi, fo;
        logic [21:0] od;
        logic [15:0] w;
`ifdef SECDED_ENC_ERR_INJ_EN
        drive_cycle(1'b0, 16'h0, 1'b1, 1'b1, 22'h000001, fi, fo, od);
        vectors++;
        if (inj_pending_o !== 1'b1) begin miscompares++; $display("FAIL inj_armed: got %b expected 1", inj_pending_o); end
        drive_cycle(1'b1, 16'h0000, 1'b1, 1'b0, 22'h0, fi, fo, od);
        vectors++;
        if (out_data_o !== 22'h2a0001) begin miscompares++; $display("FAIL inj_apply: got %h expected 2a0001", out_data_o); end
        vectors++;
        if (inj_pending_o !== 1'b0) begin miscompares++; $display("FAIL inj_clear: got %b expected 0", inj_pending_o); end
        drive_cycle(1'b1, 16'h0000, 1'b1, 1'b0, 22'h0, fi, fo, od);
        vectors++;
        if (out_data_o !== 22'h2a0000) begin miscompares++; $display("FAIL inj_next_clean: got %h expected 2a0000", out_data_o); end
        drive_cycle(1'b0, 16'h0, 1'b1, 1'b1, 22'h000003, fi, fo, od);
        w = 16'($urandom);
        drive_cycle(1'b1, w, 1'b1, 1'b0, 22'h0, fi, fo, od);
        vectors++;
        if (out_data_o !== (ref_enc(w) ^ 22'h000003)) begin miscompares++; $display("FAIL inj_double_data: got %h expected %h", out_data_o, ref_enc(w) ^ 22'h000003); end
        vectors++;
        if (ref_dec_err(out_data_o) !== 2'b10) begin miscompares++; $display("FAIL inj_double_err: got %b expected 10", ref_dec_err(out_data_o)); end
        w = 16'($urandom);
        drive_cycle(1'b1, w, 1'b1, 1'b1, 22'h000100, fi, fo, od);
        vectors++;
        if (out_data_o !== ref_enc(w)) begin miscompares++; $display("FAIL inj_arm_same_cycle: got %h expected %h", out_data_o, ref_enc(w)); end
        vectors++;
        if (inj_pending_o !== 1'b1) begin miscompares++; $display("FAIL inj_arm_same_pend: got %b expected 1", inj_pending_o); end
        drive_cycle(1'b0, 16'h0, 1'b1, 1'b1, 22'h010000, fi, fo, od);
        w = 16'($urandom);
        drive_cycle(1'b1, w, 1'b1, 1'b0, 22'h0, fi, fo, od);
        vectors++;
        if (out_data_o !== (ref_enc(w) ^ 22'h010000)) begin miscompares++; $display("FAIL inj_rearm: got %h expected %h", out_data_o, ref_enc(w) ^ 22'h010000); end
`else
        drive_cycle(1'b0, 16'h0, 1'b1, 1'b1, 22'h000001, fi, fo, od);
        vectors++;
        if (inj_pending_o !== 1'b0) begin miscompares++; $display("FAIL inj_off_pending: got %b expected 0", inj_pending_o); end
        w = 16'($urandom);
        drive_cycle(1'b1, w, 1'b1, 1'b0, 22'h0, fi, fo, od);
        vectors++;
        if (out_data_o !== ref_enc(w)) begin miscompares++; $display("FAIL inj_off_clean: got %h expected %h", out_data_o, ref_enc(w)); end
`endif
        drive_cycle(1'b0, 16'h0, 1'b1, 1'b0, 22'h0, fi, fo, od);
        vectors++;
        if (out_valid_o !== 1'b0 || exp_q.size() != 0) begin miscompares++; $display("FAIL inj_drain: valid %b left %0d expected 0", out_valid_o, exp_q.size()); end
    endtask

    task automatic test_reset_full;
        logic fi, fo;
        logic [21:0] od;
        drive_cycle(1'b1, 16'h1234, 1'b0, 1'b0, 22'h0, fi, fo, od);
        drive_cycle(1'b1, 16'h5678, 1'b0, 1'b1, 22'h0000ff, fi, fo, od);
        vectors++;
        if (in_ready_o !== 1'b0 || out_valid_o !== 1'b1) begin miscompares++; $display("FAIL rstf_full: ready %b valid %b expected 0 1", in_ready_o, out_valid_o); end
        in_valid_i = 1'b0;
        rst_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        vectors++;
        if (out_valid_o !== 1'b0) begin miscompares++; $display("FAIL rstf_valid: got %b expected 0", out_valid_o); end
        vectors++;
        if (in_ready_o !== 1'b1) begin miscompares++; $display("FAIL rstf_ready: got %b expected 1", in_ready_o); end
        vectors++;
        if (inj_pending_o !== 1'b0) begin miscompares++; $display("FAIL rstf_pending: got %b expected 0", inj_pending_o); end
        rst_i = 1'b0;
        exp_q.delete();
        pend_m = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, 16'h0, 1'b1, 1'b0, 22'h0, fi, fo, od);
            vectors++;
            if (out_valid_o !== 1'b0) begin miscompares++; $display("FAIL rstf_no_emit: got %b expected 0", out_valid_o); end
        end
        w_clean_after_reset(fi, fo, od);
    endtask

    task automatic w_clean_after_reset(output logic fi, output logic fo, output logic [21:0] od);
        logic [15:0] w;
        w = 16'($urandom);
        drive_cycle(1'b1, w, 1'b1, 1'b0, 22'h0, fi, fo, od);
        vectors++;
        if (out_data_o !== ref_enc(w)) begin miscompares++; $display("FAIL rstf_clean_word: got %h expected %h", out_data_o, ref_enc(w)); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_syndrome();
        test_backpressure();
        test_random();
        test_injection();
        test_reset_full();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
